// File: rtl/if_fetch_ctrl_if.sv
// rtl/if_fetch_ctrl_if.sv - instruction memory request/ack bus between fetch controller and imem
interface if_fetch_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) ();
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [INST_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - instruction fetch sequencer: PC, imem handshake, redirects, stall vector
module if_fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall_req_id,
  input  logic              i_stall_req_ex,
  input  logic              i_stall_req_mem,
  input  logic              i_branch_flag,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_flush_pc,
  if_fetch_ctrl_if.master   imem,
  output logic              o_if_valid,
  output logic [ADDR_W-1:0] o_if_pc,
  output logic [INST_W-1:0] o_if_inst,
  output logic [5:0]        o_stall
);
  typedef enum logic [1:0] {ST_RST_HOLD, ST_ISSUE, ST_WAIT, ST_HOLD} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_addr;
  logic              r_req;
  logic              r_if_valid;
  logic [ADDR_W-1:0] r_if_pc;
  logic [INST_W-1:0] r_if_inst;
  logic              r_pend;
  logic              r_pend_flush;
  logic [ADDR_W-1:0] r_pend_pc;

  logic [5:0]        w_stall;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_redirect_pc;
  logic              w_pend_nxt;
  logic              w_pend_flush_nxt;
  logic [ADDR_W-1:0] w_pend_pc_nxt;

  assign imem.req   = r_req;
  assign imem.addr  = r_addr;
  assign o_if_valid = r_if_valid;
  assign o_if_pc    = r_if_pc;
  assign o_if_inst  = r_if_inst;
  assign o_stall    = w_stall;

  assign w_redirect    = i_flush | i_branch_flag;
  assign w_redirect_pc = i_flush ? i_flush_pc : i_branch_target;

  // Stall vector: the deepest requesting stage freezes itself and everything upstream
  always_comb begin
    w_stall = 6'b000000;
    if (rst)                  w_stall = 6'b000000;
    else if (i_stall_req_mem) w_stall = 6'b011111;
    else if (i_stall_req_ex)  w_stall = 6'b001111;
    else if (i_stall_req_id)  w_stall = 6'b000111;
  end

  // Pending redirect merge while a fetch is outstanding; a flush is never displaced by a branch
  always_comb begin
    w_pend_nxt       = r_pend;
    w_pend_flush_nxt = r_pend_flush;
    w_pend_pc_nxt    = r_pend_pc;
    if (i_flush) begin
      w_pend_nxt       = 1'b1;
      w_pend_flush_nxt = 1'b1;
      w_pend_pc_nxt    = i_flush_pc;
    end else if (i_branch_flag && !r_pend_flush) begin
      w_pend_nxt       = 1'b1;
      w_pend_flush_nxt = 1'b0;
      w_pend_pc_nxt    = i_branch_target;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RST_HOLD: w_state_nxt = ST_ISSUE;
      ST_ISSUE:    if (!w_redirect && !w_stall[0]) w_state_nxt = ST_WAIT;
      ST_WAIT:     if (imem.ack) w_state_nxt = (w_pend_nxt || !w_stall[1]) ? ST_ISSUE : ST_HOLD;
      ST_HOLD:     if (!w_stall[1]) w_state_nxt = ST_ISSUE;
      default:     w_state_nxt = ST_RST_HOLD;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RST_HOLD;
    else     r_state <= w_state_nxt;
  end

  // PC, request, IF/ID register and pending-redirect datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_addr       <= RESET_PC;
      r_req        <= 1'b0;
      r_if_valid   <= 1'b0;
      r_if_pc      <= '0;
      r_if_inst    <= '0;
      r_pend       <= 1'b0;
      r_pend_flush <= 1'b0;
      r_pend_pc    <= '0;
    end else begin
      // IF/ID takes the instruction whenever it is not held
      if (!w_stall[1]) r_if_valid <= 1'b0;
      case (r_state)
        ST_RST_HOLD, ST_HOLD: begin
          if (w_redirect) begin
            r_pc       <= w_redirect_pc;
            r_if_valid <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (w_redirect) begin
            r_pc       <= w_redirect_pc;
            r_if_valid <= 1'b0;
          end else if (!w_stall[0]) begin
            r_req  <= 1'b1;
            r_addr <= r_pc;
          end
        end
        ST_WAIT: begin
          r_pend       <= w_pend_nxt;
          r_pend_flush <= w_pend_flush_nxt;
          r_pend_pc    <= w_pend_pc_nxt;
          if (w_redirect) r_if_valid <= 1'b0;
          if (imem.ack) begin
            r_req        <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_flush <= 1'b0;
            if (w_pend_nxt) begin
              r_pc       <= w_pend_pc_nxt;
              r_if_valid <= 1'b0;
            end else begin
              r_if_inst  <= imem.rdata;
              r_if_pc    <= r_addr;
              r_if_valid <= 1'b1;
              r_pc       <= r_addr + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - directed self-checking bench for if_fetch_ctrl
module tb_if_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall_req_id, stall_req_ex, stall_req_mem;
  logic        branch_flag, flush;
  logic [31:0] branch_target, flush_pc;
  logic        if_valid;
  logic [31:0] if_pc, if_inst;
  logic [5:0]  stall;
  int          n_tests = 0;
  int          n_fail  = 0;

  if_fetch_ctrl_if #(.ADDR_W(32), .INST_W(32)) imem_if ();

  if_fetch_ctrl #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_stall_req_id  (stall_req_id),
    .i_stall_req_ex  (stall_req_ex),
    .i_stall_req_mem (stall_req_mem),
    .i_branch_flag   (branch_flag),
    .i_branch_target (branch_target),
    .i_flush         (flush),
    .i_flush_pc      (flush_pc),
    .imem            (imem_if),
    .o_if_valid      (if_valid),
    .o_if_pc         (if_pc),
    .o_if_inst       (if_inst),
    .o_stall         (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] sreq;
    logic [5:0] stall_exp [8];
    stall_exp = '{6'b000000, 6'b000111, 6'b001111, 6'b001111,
                  6'b011111, 6'b011111, 6'b011111, 6'b011111};

    rst = 1'b1;
    stall_req_id = 0; stall_req_ex = 0; stall_req_mem = 1;
    branch_flag = 0; flush = 0; branch_target = 0; flush_pc = 0;
    imem_if.ack = 0; imem_if.rdata = 0;
    step(); step();
    check("rst_stall", {58'd0, stall}, 64'd0);
    check("rst_req", {63'd0, imem_if.req}, 64'd0);
    check("rst_addr", {32'd0, imem_if.addr}, 64'd0);
    check("rst_valid", {63'd0, if_valid}, 64'd0);
    check("rst_if_pc", {32'd0, if_pc}, 64'd0);
    check("rst_if_inst", {32'd0, if_inst}, 64'd0);
    stall_req_mem = 0;
    rst = 1'b0;
    step();
    check("idle_req", {63'd0, imem_if.req}, 64'd0);
    step();
    check("first_req", {63'd0, imem_if.req}, 64'd1);

    // 1: zero-wait sequential fetch
    for (int i = 0; i < 4; i++) begin
      check("seq_addr", {32'd0, imem_if.addr}, 64'(i));
      imem_if.ack = 1; imem_if.rdata = 32'hA000 + 32'(i);
      step();
      imem_if.ack = 0;
      check("seq_valid", {63'd0, if_valid}, 64'd1);
      check("seq_if_pc", {32'd0, if_pc}, 64'(i));
      check("seq_if_inst", {32'd0, if_inst}, 64'hA000 + 64'(i));
      step();
      check("seq_valid_consumed", {63'd0, if_valid}, 64'd0);
      check("seq_req", {63'd0, imem_if.req}, 64'd1);
    end

    // 2: EX stall on ack -> HOLD
    stall_req_ex = 1; imem_if.ack = 1; imem_if.rdata = 32'hB4;
    step();
    imem_if.ack = 0;
    for (int i = 0; i < 3; i++) begin
      check("hold_stall", {58'd0, stall}, 64'b001111);
      check("hold_req", {63'd0, imem_if.req}, 64'd0);
      check("hold_valid", {63'd0, if_valid}, 64'd1);
      check("hold_if_pc", {32'd0, if_pc}, 64'd4);
      check("hold_if_inst", {32'd0, if_inst}, 64'hB4);
      step();
    end
    stall_req_ex = 0;
    step();
    check("hold_exit_valid", {63'd0, if_valid}, 64'd0);
    check("hold_exit_req", {63'd0, imem_if.req}, 64'd0);
    step();
    check("resume_req", {63'd0, imem_if.req}, 64'd1);
    check("resume_addr", {32'd0, imem_if.addr}, 64'd5);

    // 3: branch raised in WAIT two cycles before ack
    branch_flag = 1; branch_target = 32'h40;
    step();
    branch_flag = 0;
    check("br_addr_stable", {32'd0, imem_if.addr}, 64'd5);
    step();
    imem_if.ack = 1; imem_if.rdata = 32'hDEAD;
    step();
    imem_if.ack = 0;
    check("br_drop_valid", {63'd0, if_valid}, 64'd0);
    check("br_drop_if_pc", {32'd0, if_pc}, 64'd4);
    step();
    check("br_addr", {32'd0, imem_if.addr}, 64'h40);
    check("br_req", {63'd0, imem_if.req}, 64'd1);

    // 4: pending branch overwritten by flush
    branch_flag = 1; branch_target = 32'h40;
    step();
    branch_flag = 0; flush = 1; flush_pc = 32'h80;
    step();
    flush = 0; imem_if.ack = 1; imem_if.rdata = 32'hBEEF;
    step();
    imem_if.ack = 0;
    check("fl_drop_valid", {63'd0, if_valid}, 64'd0);
    step();
    check("fl_addr", {32'd0, imem_if.addr}, 64'h80);

    // 5: PC wrap
    imem_if.ack = 1; imem_if.rdata = 32'h80;
    step();
    imem_if.ack = 0;
    check("fl_fetch_if_pc", {32'd0, if_pc}, 64'h80);
    flush = 1; flush_pc = 32'hFFFF_FFFF;
    step();
    flush = 0;
    check("wrap_redir_valid", {63'd0, if_valid}, 64'd0);
    step();
    check("wrap_addr_max", {32'd0, imem_if.addr}, 64'hFFFF_FFFF);
    imem_if.ack = 1; imem_if.rdata = 32'h1234;
    step();
    imem_if.ack = 0;
    check("wrap_if_pc", {32'd0, if_pc}, 64'hFFFF_FFFF);
    check("wrap_valid", {63'd0, if_valid}, 64'd1);
    step();
    check("wrap_addr_zero", {32'd0, imem_if.addr}, 64'd0);
    check("wrap_req", {63'd0, imem_if.req}, 64'd1);

    // 6: reset mid-WAIT with late ack
    rst = 1; imem_if.ack = 1; imem_if.rdata = 32'hCAFE;
    step();
    rst = 0;
    check("midrst_req", {63'd0, imem_if.req}, 64'd0);
    check("midrst_valid", {63'd0, if_valid}, 64'd0);
    step();
    check("late_ack_valid", {63'd0, if_valid}, 64'd0);
    check("late_ack_req", {63'd0, imem_if.req}, 64'd0);
    step();
    imem_if.ack = 0;
    check("post_rst_valid", {63'd0, if_valid}, 64'd0);
    check("post_rst_req", {63'd0, imem_if.req}, 64'd1);
    check("post_rst_addr", {32'd0, imem_if.addr}, 64'd0);

    // Stall priority table {mem,ex,id}
    for (int i = 0; i < 8; i++) begin
      sreq = 3'(i);
      stall_req_mem = sreq[2]; stall_req_ex = sreq[1]; stall_req_id = sreq[0];
      #1;
      check("stall_prio", {58'd0, stall}, {58'd0, stall_exp[i]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
